// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus_main definitions: arbiter states, address field bounds, command codes
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    ERR   = 3'd4
  } arb_state_t;

  localparam int BUS_ADDR_HI = 28;
  localparam int BUS_ADDR_LO = 2;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request searching circularly from last+1
module rr_pick #(
  parameter int N  = 2,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic          any,
  output logic [GW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [GW-1:0] probe;

  // Walk from the farthest candidate back to last+1 so the nearest hit overwrites the others.
  always_comb begin
    any   = 1'b0;
    idx   = '0;
    probe = '0;
    for (int k = N; k >= 1; k--) begin
      probe = GW'((int'(last) + k) % N);
      if (req[probe]) begin
        any = 1'b1;
        idx = probe;
      end
    end
    onehot = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/bus_arb.sv
// rtl/bus_arb.sv - round-robin arbiter sharing one bus_main master port among N requesters
module bus_arb
  import bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = $clog2(N)
) (
  input  logic                                    clk_core,
  input  logic                                    reset_n,
  input  logic [N-1:0]                            req_cvalid,
  output logic [N-1:0]                            arb_cready,
  input  logic [N-1:0]                            req_cmd,
  input  logic [N-1:0][BUS_ADDR_HI:BUS_ADDR_LO]   req_addr,
  input  logic [N-1:0]                            req_wvalid,
  output logic [N-1:0]                            arb_wready,
  input  logic [N-1:0]                            req_wlast,
  input  logic [N-1:0][31:0]                      req_wdata,
  input  logic [N-1:0][3:0]                       req_wmask,
  output logic [N-1:0]                            arb_rvalid,
  input  logic [N-1:0]                            req_rready,
  output logic [N-1:0]                            arb_error,
  input  logic [N-1:0]                            req_eack,
  output logic                                    arb_rlast,
  output logic [31:0]                             arb_rdata,
  output logic                                    arb_cvalid,
  input  logic                                    bmain_cready,
  output logic                                    arb_cmd,
  output logic [BUS_ADDR_HI:BUS_ADDR_LO]          arb_addr,
  output logic                                    arb_wvalid,
  input  logic                                    bmain_wready,
  output logic                                    arb_wlast,
  output logic [31:0]                             arb_wdata,
  output logic [3:0]                              arb_wmask,
  input  logic                                    bmain_rvalid,
  output logic                                    arb_rready,
  input  logic                                    bmain_rlast,
  input  logic [31:0]                             bmain_rdata,
  input  logic                                    bmain_error,
  output logic                                    arb_eack
);

  arb_state_t                     state;
  logic [GW-1:0]                  last;
  logic [GW-1:0]                  grant;
  logic                           cmd_q;
  logic [BUS_ADDR_HI:BUS_ADDR_LO] addr_q;

  logic                           pick_any;
  logic [GW-1:0]                  pick_idx;
  logic [N-1:0]                   pick_onehot;
  logic                           w_done;
  logic                           r_done;
  logic                           e_done;

  rr_pick #(
    .N  (N),
    .GW (GW)
  ) u_pick (
    .req    (req_cvalid),
    .last   (last),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    arb_cready = '0;
    arb_wready = '0;
    arb_rvalid = '0;
    arb_error  = '0;
    arb_cvalid = 1'b0;
    arb_cmd    = cmd_q;
    arb_addr   = addr_q;
    arb_wvalid = 1'b0;
    arb_wlast  = req_wlast[grant];
    arb_wdata  = req_wdata[grant];
    arb_wmask  = req_wmask[grant];
    arb_rready = 1'b0;
    arb_rlast  = bmain_rlast;
    arb_rdata  = bmain_rdata;
    arb_eack   = 1'b0;
    unique case (state)
      // Gated by reset_n so an asserted reset silences cready even with requests pending.
      IDLE:  arb_cready = reset_n ? pick_onehot : '0;
      CMD:   arb_cvalid = 1'b1;
      WDATA: begin
        if (!bmain_error) begin
          arb_wvalid        = req_wvalid[grant];
          arb_wready[grant] = bmain_wready;
        end
      end
      RDATA: begin
        if (!bmain_error) begin
          arb_rvalid[grant] = bmain_rvalid;
          arb_rready        = req_rready[grant];
        end
      end
      ERR: begin
        arb_error[grant] = 1'b1;
        arb_eack         = req_eack[grant];
      end
      default: ;
    endcase
  end

  assign w_done = arb_wvalid & bmain_wready & arb_wlast;
  assign r_done = bmain_rvalid & arb_rready & bmain_rlast;
  assign e_done = bmain_error & arb_eack;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      last   <= GW'(N - 1);
      grant  <= '0;
      cmd_q  <= CMD_WRITE;
      addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant  <= pick_idx;
            cmd_q  <= req_cmd[pick_idx];
            addr_q <= req_addr[pick_idx];
            state  <= CMD;
          end
        end
        CMD: begin
          if (bmain_error) begin
            state <= ERR;
          end else if (bmain_cready) begin
            state <= (cmd_q == CMD_READ) ? RDATA : WDATA;
          end
        end
        WDATA: begin
          if (bmain_error) begin
            state <= ERR;
          end else if (w_done) begin
            last  <= grant;
            state <= IDLE;
          end
        end
        RDATA: begin
          if (bmain_error) begin
            state <= ERR;
          end else if (r_done) begin
            last  <= grant;
            state <= IDLE;
          end
        end
        ERR: begin
          if (e_done) begin
            last  <= grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// tb/tb_bus_arb.sv - self-checking bench for bus_arb with table vectors, corner sequences and random traffic
module tb_bus_arb;
  import bus_pkg::*;

  localparam int N = 3;
  typedef logic [BUS_ADDR_HI:BUS_ADDR_LO] addr_t;

  logic                 clk_core = 1'b0;
  logic                 reset_n;
  logic [N-1:0]         req_cvalid, arb_cready, req_cmd, req_wvalid, arb_wready, req_wlast;
  logic [N-1:0]         arb_rvalid, req_rready, arb_error, req_eack;
  logic [N-1:0][BUS_ADDR_HI:BUS_ADDR_LO] req_addr;
  logic [N-1:0][31:0]   req_wdata;
  logic [N-1:0][3:0]    req_wmask;
  logic                 arb_rlast, arb_cvalid, bmain_cready, arb_cmd, arb_wvalid, bmain_wready;
  logic                 arb_wlast, bmain_rvalid, arb_rready, bmain_rlast, bmain_error, arb_eack;
  logic [31:0]          arb_rdata, arb_wdata, bmain_rdata;
  logic [3:0]           arb_wmask;
  addr_t                arb_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int m_last  = N - 1;

  bus_arb #(.N(N)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .req_cvalid(req_cvalid), .arb_cready(arb_cready), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wvalid(req_wvalid), .arb_wready(arb_wready), .req_wlast(req_wlast), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .arb_rvalid(arb_rvalid), .req_rready(req_rready), .arb_error(arb_error),
    .req_eack(req_eack), .arb_rlast(arb_rlast), .arb_rdata(arb_rdata), .arb_cvalid(arb_cvalid),
    .bmain_cready(bmain_cready), .arb_cmd(arb_cmd), .arb_addr(arb_addr), .arb_wvalid(arb_wvalid),
    .bmain_wready(bmain_wready), .arb_wlast(arb_wlast), .arb_wdata(arb_wdata), .arb_wmask(arb_wmask),
    .bmain_rvalid(bmain_rvalid), .arb_rready(arb_rready), .bmain_rlast(bmain_rlast),
    .bmain_rdata(bmain_rdata), .bmain_error(bmain_error), .arb_eack(arb_eack)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h required %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic idle_inputs();
    req_cvalid = '0; req_cmd = '0; req_addr = '0; req_wvalid = '0; req_wlast = '0;
    req_wdata = '0; req_wmask = '0; req_rready = '0; req_eack = '0;
    bmain_cready = 1'b0; bmain_wready = 1'b0; bmain_rvalid = 1'b0; bmain_rlast = 1'b0;
    bmain_rdata = '0; bmain_error = 1'b0;
  endtask

  task automatic chk_quiet(input string nm);
    chk(nm, {arb_cready, arb_wready, arb_rvalid, arb_error, arb_cvalid, arb_wvalid, arb_rready, arb_eack}, 0);
  endtask

  // Reference rule: the winner is the first requesting index after the previous winner, wrapping.
  function automatic int model_pick(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++)
      if (mask[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // mode: 0 no waits, 1 random waits, 2 wready toggles 1,0,1..., 3 rready low for data cycles 2..6
  task automatic do_txn(input logic [N-1:0] mask, input logic cmd, input addr_t addr,
                        input int len, input int exp_w, input int mode);
    logic [31:0]  d [16];
    logic [N-1:0] oh;
    int           i, cyc;
    logic         done;
    oh = N'(1) << exp_w;
    for (int k = 0; k < 16; k++) d[k] = $urandom;
    req_cvalid = mask;
    for (int j = 0; j < N; j++) begin
      req_cmd[j]  = cmd;
      req_addr[j] = addr + addr_t'(j);
    end
    #2;
    chk("idle_cready", arb_cready, oh);
    chk("idle_err_eack", {arb_error, arb_eack}, 0);
    tick();
    req_cvalid = mask & ~oh;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 100) begin
      bmain_cready = (mode == 1) ? 1'($urandom) : 1'b1;
      #2;
      chk("cmd_cvalid", arb_cvalid, 1);
      chk("cmd_fields", {arb_cmd, arb_addr}, {cmd, addr + addr_t'(exp_w)});
      chk("cmd_no_cready", arb_cready, 0);
      done = bmain_cready;
      tick();
      cyc++;
    end
    if (!done) chk("cmd_timeout", 0, 1);
    bmain_cready = 1'b0;
    i   = 0;
    cyc = 0;
    while (i < len && cyc < 200) begin
      if (cmd == CMD_WRITE) begin
        for (int j = 0; j < N; j++) begin
          req_wvalid[j] = 1'b1;
          req_wdata[j]  = (j == exp_w) ? d[i] : ~d[i];
          req_wmask[j]  = (j == exp_w) ? d[i][3:0] : ~d[i][3:0];
          req_wlast[j]  = (j == exp_w) ? (i == len - 1) : 1'b1;
        end
        req_wvalid[exp_w] = (mode == 1) ? 1'($urandom) : 1'b1;
        bmain_wready = (mode == 1) ? 1'($urandom) : (mode == 2) ? (cyc % 2 == 0) : 1'b1;
        #2;
        chk("w_wvalid", arb_wvalid, req_wvalid[exp_w]);
        chk("w_wready", arb_wready, bmain_wready ? oh : '0);
        chk("w_beat", {arb_wlast, arb_wmask, arb_wdata}, {i == len - 1, d[i][3:0], d[i]});
        chk("w_no_rside", {arb_rvalid, arb_rready, arb_cready}, 0);
        if (req_wvalid[exp_w] && bmain_wready) i++;
      end else begin
        req_rready = '1;
        req_rready[exp_w] = (mode == 1) ? 1'($urandom) : (mode == 3) ? !(cyc >= 2 && cyc < 7) : 1'b1;
        bmain_rvalid = (mode == 1) ? 1'($urandom) : 1'b1;
        bmain_rdata  = d[i];
        bmain_rlast  = (i == len - 1);
        #2;
        chk("r_rvalid", arb_rvalid, bmain_rvalid ? oh : '0);
        chk("r_rready", arb_rready, req_rready[exp_w]);
        chk("r_beat", {arb_rlast, arb_rdata}, {i == len - 1, d[i]});
        chk("r_no_wside", {arb_wvalid, arb_wready, arb_cready}, 0);
        if (bmain_rvalid && req_rready[exp_w]) i++;
      end
      tick();
      cyc++;
    end
    if (i < len) chk("data_timeout", i, len);
    idle_inputs();
    m_last = exp_w;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic         cmd;
    int           len;
    logic [N-1:0] exp_cready;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{3'b011, CMD_READ,  1, 3'b001};
    vecs[1] = '{3'b011, CMD_READ,  1, 3'b010};
    vecs[2] = '{3'b111, CMD_WRITE, 2, 3'b100};
    vecs[3] = '{3'b110, CMD_READ,  1, 3'b010};
    vecs[4] = '{3'b001, CMD_WRITE, 1, 3'b001};
    vecs[5] = '{3'b101, CMD_READ,  3, 3'b100};
    vecs[6] = '{3'b100, CMD_WRITE, 1, 3'b100};
    vecs[7] = '{3'b110, CMD_READ,  2, 3'b010};

    idle_inputs();
    reset_n    = 1'b0;
    req_cvalid = '1;
    #3;
    chk_quiet("reset_outputs");
    chk("reset_cmd_addr", {arb_cmd, arb_addr}, 0);
    tick();
    tick();
    req_cvalid = '0;
    reset_n    = 1'b1;
    m_last     = N - 1;

    for (int v = 0; v < 8; v++)
      do_txn(vecs[v].mask, vecs[v].cmd, addr_t'($urandom), vecs[v].len, $clog2(vecs[v].exp_cready), 0);

    for (int k = 0; k < 6; k++)
      do_txn(3'b111, CMD_READ, addr_t'(k * 16), 1, (2 + k) % 3, 0);

    do_txn(3'b010, CMD_WRITE, addr_t'(32'h1000_0000 >> 2), 4, 1, 2);
    do_txn(3'b010, CMD_READ, addr_t'(32'h0800_0000 >> 2), 8, 1, 3);

    idle_inputs();
    req_cvalid  = 3'b001;
    req_cmd     = '1;
    req_addr[0] = addr_t'(32'h3000_0000 >> 2);
    #2 chk("err_cready", arb_cready, 3'b001);
    tick();
    req_cvalid   = '0;
    bmain_cready = 1'b1;
    #2 chk("err_cmd_cvalid", arb_cvalid, 1);
    tick();
    bmain_cready = 1'b0;
    bmain_error  = 1'b1;
    bmain_rvalid = 1'b1;
    req_rready   = '1;
    #2 chk("err_cut_beat", {arb_rvalid, arb_rready, arb_error}, 0);
    tick();
    bmain_rvalid = 1'b0;
    #2 chk("err_flag", {arb_error, arb_eack, arb_rvalid}, {3'b001, 1'b0, 3'b000});
    tick();
    req_eack[0] = 1'b1;
    #2 chk("err_eack", {arb_error, arb_eack}, {3'b001, 1'b1});
    tick();
    idle_inputs();
    m_last = 0;
    do_txn(3'b011, CMD_READ, addr_t'(5), 1, 1, 0);

    idle_inputs();
    req_cvalid = 3'b010;
    #2 chk("rst_cready", arb_cready, 3'b010);
    tick();
    req_cvalid   = '0;
    bmain_cready = 1'b1;
    tick();
    bmain_cready = 1'b0;
    req_wvalid   = '1;
    bmain_wready = 1'b1;
    #2 chk("rst_pre_beat", {arb_wvalid, arb_wready}, {1'b1, 3'b010});
    tick();
    req_cvalid = '1;
    #2 chk("rst_mid_burst", {arb_wvalid, arb_wready}, {1'b1, 3'b010});
    reset_n = 1'b0;
    #1 chk_quiet("rst_async_outputs");
    tick();
    tick();
    idle_inputs();
    reset_n = 1'b1;
    m_last  = N - 1;
    do_txn(3'b011, CMD_WRITE, addr_t'(9), 2, 0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, (1 << N) - 1));
      do_txn(mask, 1'($urandom), addr_t'($urandom), $urandom_range(1, 4), model_pick(mask, m_last), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
# bus_arb

Round-robin arbiter that shares one `bus_main` master port among `N` requesters, such as fetch1, memory1 and a future DMA or page-table walker. It owns one transaction at a time: command accept, write or read data burst, and optional error acknowledge. It routes every beat between the granted requester and `bus_main`, then rotates priority. It replaces fixed priority with starvation-free sharing and sits directly upstream of a `bus_main` master port.

## Interface

**Parameters**
- `N`, default 2: number of requesters, 2..8.
- `GW`, default `$clog2(N)`: grant index width. Derived; do not override.

**Ports** (per-requester signals are packed `[N-1:0]` vectors or `[N-1:0][w]` arrays, index = requester)
- `clk_core` in 1: core clock.
- `reset_n` in 1: reset is asynchronous and active-low.
- `req_cvalid` in N: command valid.
- `arb_cready` out N: command accepted.
- `req_cmd` in N: 1 = read, 0 = write.
- `req_addr` in N×[28:2]: word address.
- `req_wvalid` in N: write data valid.
- `arb_wready` out N: write data ready.
- `req_wlast` in N: last write beat.
- `req_wdata` in N×32: write data.
- `req_wmask` in N×4: byte mask.
- `arb_rvalid` out N: read data valid.
- `req_rready` in N: read data ready.
- `arb_error` out N: access error.
- `req_eack` in N: error acknowledge.
- `arb_rlast` out 1: shared rlast.
- `arb_rdata` out 32: shared rdata.
- `arb_cvalid` out 1: command valid to `bus_main`.
- `bmain_cready` in 1: command ready from `bus_main`.
- `arb_cmd` out 1: forwarded command.
- `arb_addr` out [28:2]: forwarded address.
- `arb_wvalid` out 1: write valid to `bus_main`.
- `bmain_wready` in 1: write ready from `bus_main`.
- `arb_wlast` out 1: forwarded wlast.
- `arb_wdata` out 32: forwarded wdata.
- `arb_wmask` out 4: forwarded wmask.
- `bmain_rvalid` in 1: read valid from `bus_main`.
- `arb_rready` out 1: read ready to `bus_main`.
- `bmain_rlast` in 1: read last from `bus_main`.
- `bmain_rdata` in 32: read data from `bus_main`.
- `bmain_error` in 1: error from `bus_main`.
- `arb_eack` out 1: error acknowledge to `bus_main`.

## Operation

**State machine** (`state`):
- **IDLE**
  - The winner `w` is the first index with `req_cvalid` set, searching circularly from `last+1`.
  - `arb_cready[w]=1` combinationally, in the same cycle as the request.
  - On that beat, register `grant<=w`, `cmd_q<=req_cmd[w]` and `addr_q<=req_addr[w]`, then go to CMD.
  - With no request, remain in IDLE.
- **CMD**
  - `arb_cvalid=1`, `arb_cmd=cmd_q`, `arb_addr=addr_q`; these stay stable until `bmain_cready`.
  - On `bmain_cready`, go to RDATA if `cmd_q=1`, otherwise to WDATA.
- **WDATA**
  - `arb_wvalid=req_wvalid[grant]`, `arb_wready[grant]=bmain_wready`, and wlast/wdata/wmask come from `grant`.
  - On the beat with wlast, `last<=grant` and go to IDLE.
- **RDATA**
  - `arb_rvalid[grant]=bmain_rvalid`, `arb_rready=req_rready[grant]`, and `arb_rlast`/`arb_rdata` pass through.
  - On the beat with rlast, `last<=grant` and go to IDLE.
- **ERR**
  - `arb_error[grant]=1` and `arb_eack=req_eack[grant]`.
  - On the eack beat (`bmain_error & arb_eack`), `last<=grant` and go to IDLE.

**Errors**
- `bmain_error` in CMD, WDATA or RDATA causes a transition to ERR on the next cycle.
- In that cycle, `arb_wvalid`, `arb_wready`, `arb_rvalid` and `arb_rready` are forced to 0, so no data beat completes.

**Routing**
- Non-granted requesters, and every requester outside its phase, see `arb_cready`, `arb_wready`, `arb_rvalid` and `arb_error` at 0.

**Reset values**
- `state=IDLE`, `last=N-1` (requester 0 wins first), `grant=0`, `cmd_q=0`, `addr_q=0`.
- All valid, ready, error and eack outputs are 0.
- `arb_rdata` and `arb_wdata` are pass-through or don't-care.

**Reset mid-transaction**
- The block returns immediately to IDLE.
- It does not drain `bus_main`; `bus_main` is reset by the same `reset_n`.

## Timing

- Request to `arb_cvalid`: 1 cycle. The `cready` pulse is in cycle 0; `arb_cvalid` is high from cycle 1.
- Data beats add zero latency; they are purely combinational pass-through.
- Completion to next grant: 1 cycle. The last beat is in cycle k, IDLE in cycle k+1, and `cready` to the next winner in k+1.
- Simultaneous requests in IDLE: exactly one `cready` is asserted; losers hold `req_cvalid` and their payload.
- Fairness: with all N requesting continuously, each requester is granted once every N transactions.
- Single-beat and zero-wait-state transactions are legal: CMD, then WDATA/RDATA for one cycle, then IDLE.

## Structure

- Shared package `bus_pkg`:
  - `arb_state_t` enum {IDLE, CMD, WDATA, RDATA, ERR}.
  - `BUS_ADDR_HI=28`, `BUS_ADDR_LO=2`.
  - `CMD_READ=1'b1`, `CMD_WRITE=1'b0`.
- Sub-module `rr_pick #(N)`:
  - Inputs `req[N]`, `last[GW]`.
  - Outputs `any`, `idx[GW]`, `onehot[N]`.
  - Purely combinational; reusable by a future MMIO arbiter.

## Test plan

- **Reset start:** N=2, both request reads at cycle 0 → `arb_cready=2'b01` in cycle 0; req1 is granted only after req0's rlast beat (1 cycle later).
- **Rotation:** N=3, all three continuously request 1-beat reads → grant order 0,1,2,0,1,2; no requester is granted twice before the others.
- **Write burst with backpressure:** req1 writes 4 beats to `0x10000000`, `bmain_wready` toggles 1,0,1,0… → exactly 4 beats forwarded in order, and `arb_wready[0]` stays 0 throughout.
- **Error:** req0 reads `0x30000000`, `bmain_error` goes high in RDATA → `arb_error=2'b01`, no `arb_rvalid`, and IDLE one cycle after the `req_eack[0]` beat.
- **Read stall:** `req_rready[1]=0` for 5 cycles during an 8-beat read → `arb_rready` is 0 for those cycles; all 8 beats arrive in order, with `arb_rlast` only on beat 8.
- **Reset mid-burst:** `reset_n` low during WDATA → all outputs 0 asynchronously; after release, requester 0 wins first.
